period_capture: RTL

//  Measures the period between successive edges of the crank-tooth input in clk ticks.

---
 rtl/hwag_pkg.sv | 27 ++
 rtl/period_capture_if.sv | 31 +++
 rtl/hwag_edge_detect.sv | 92 +++++++++
 rtl/period_capture.sv | 121 ++++++++++++
 4 files changed

// File: rtl/hwag_pkg.sv
// Package: hwag_pkg
// Shared types and constants for the crank-tooth period capture block.
//   WIDTH      period counter / capture register width
//   FILT_LEN   consecutive stable samples the optional glitch filter needs
//   period_t   one measured period in clk ticks
//   CNT_MAX    saturation value of the period counter (input lost)
//   EDGE_RISE / EDGE_FALL  encodings of the edge_sel input
//   cap_state_e  timing state: idle until the first edge, then timing

package hwag_pkg;

  localparam int WIDTH    = 16;
  localparam int FILT_LEN = 4;

  typedef logic [WIDTH-1:0] period_t;

  localparam period_t CNT_MAX = {WIDTH{1'b1}};

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_TIMING
  } cap_state_e;

endpackage

// File: rtl/period_capture_if.sv
// Interface: period_capture_if
// Bundles the control inputs and the measurement results of period_capture.
//   en, edge_sel, cap_in               driven by the master (controller / sensor side)
//   cnt, cap0..cap2, cap_valid,
//   hist_full, timeout                 driven by the slave (period_capture)

interface period_capture_if;
  import hwag_pkg::*;

  logic    en;
  logic    edge_sel;
  logic    cap_in;
  period_t cnt;
  period_t cap0;
  period_t cap1;
  period_t cap2;
  logic    cap_valid;
  logic    hist_full;
  logic    timeout;

  modport master (
    output en, edge_sel, cap_in,
    input  cnt, cap0, cap1, cap2, cap_valid, hist_full, timeout
  );

  modport slave (
    input  en, edge_sel, cap_in,
    output cnt, cap0, cap1, cap2, cap_valid, hist_full, timeout
  );

endinterface

// File: rtl/hwag_edge_detect.sv
// Module: hwag_edge_detect
// Brings the asynchronous crank sensor pin into the clk domain and produces a
// one-cycle tooth-event strobe on the selected edge.
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   cap_in    raw sensor pin, asynchronous to clk
//   edge_sel  EDGE_RISE / EDGE_FALL
//   edge_out  combinational strobe; the consumer registers on the next clk edge
// Optional feature macro: PERIOD_CAPTURE_FILTER_EN inserts a FILT_LEN-sample
// stability filter between the synchronizer and the edge detector.

module hwag_edge_detect
  import hwag_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic cap_in,
  input  logic edge_sel,
  output logic edge_out
);

  logic       sync1_q;
  logic       sync2_q;
  logic       level;
  logic       prev_q;
  logic [1:0] warm_q;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= cap_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef PERIOD_CAPTURE_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);

  logic [FW-1:0] stable_q;
  logic          filt_q;

  // The filtered level follows the synchronized pin only after FILT_LEN
  // consecutive samples that disagree with it; any agreeing sample restarts
  // the run, so shorter pulses never reach the edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      filt_q   <= 1'b0;
    end else if (sync2_q == filt_q) begin
      stable_q <= '0;
    end else if (stable_q == FW'(FILT_LEN - 1)) begin
      stable_q <= '0;
      filt_q   <= sync2_q;
    end else begin
      stable_q <= stable_q + 1'b1;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  // prev_q only holds a real pin sample after three clocks out of reset;
  // warm_q masks the comparison against the reset value until then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      warm_q <= 2'd0;
    end else begin
      prev_q <= level;
      if (warm_q != 2'd3) begin
        warm_q <= warm_q + 2'd1;
      end
    end
  end

  always_comb begin
    edge_out = 1'b0;
    if (warm_q == 2'd3) begin
      if (edge_sel == EDGE_RISE) begin
        edge_out = level & ~prev_q;
      end else begin
        edge_out = prev_q & ~level;
      end
    end
  end

endmodule

// File: rtl/period_capture.sv
// Module: period_capture
// Measures the tick distance between successive crank-tooth events and keeps a
// three-deep history (cap0 newest, cap2 oldest) for the plausibility checker
// and the tooth/gap logic.
//   clk, rst_n      system clock, asynchronous active-low reset
//   bus (slave)     en, edge_sel, cap_in in;
//                   cnt, cap0, cap1, cap2, cap_valid, hist_full, timeout out
// Optional feature macro: PERIOD_CAPTURE_FILTER_EN (glitch filter inside
// hwag_edge_detect, adds FILT_LEN cycles of latency).

module period_capture
  import hwag_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  period_capture_if.slave bus
);

  cap_state_e state_q;
  cap_state_e state_d;
  period_t    cnt_q;
  period_t    cap0_q;
  period_t    cap1_q;
  period_t    cap2_q;
  logic       valid_q;
  logic [1:0] fill_q;
  logic       edge_raw;
  logic       edge_ev;
  logic       at_max;
  logic       trusted_edge;

  hwag_edge_detect u_edge_detect (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap_in   (bus.cap_in),
    .edge_sel (bus.edge_sel),
    .edge_out (edge_raw)
  );

  assign at_max  = (cnt_q == CNT_MAX);
  assign edge_ev = edge_raw & bus.en;

  // Timing state: IDLE until the first event after reset or after en rises,
  // which only starts the measurement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A trusted edge closes a real period that did not saturate.
  always_comb begin
    state_d      = state_q;
    trusted_edge = 1'b0;
    if (!bus.en) begin
      state_d = ST_IDLE;
    end else if (edge_ev) begin
      state_d      = ST_TIMING;
      trusted_edge = (state_q == ST_TIMING) && !at_max;
    end
  end

  // Counter stays at 0 while idle so the syncing edge captures 0; the edge
  // cycle itself counts, hence the reload to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!bus.en) begin
      cnt_q <= '0;
    end else if (edge_ev) begin
      cnt_q <= period_t'(1);
    end else if ((state_q == ST_TIMING) && !at_max) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // History shift; a saturated count is captured as is so downstream logic
  // can see the input was lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap0_q  <= '0;
      cap1_q  <= '0;
      cap2_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= edge_ev;
      if (edge_ev) begin
        cap2_q <= cap1_q;
        cap1_q <= cap0_q;
        cap0_q <= cnt_q;
      end
    end
  end

  // Fill counts trusted periods since the last resync. The syncing edge,
  // a saturated edge and an ongoing timeout all restart it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= 2'd0;
    end else if (!bus.en) begin
      fill_q <= 2'd0;
    end else if (trusted_edge) begin
      if (fill_q != 2'd3) begin
        fill_q <= fill_q + 2'd1;
      end
    end else if (edge_ev || at_max) begin
      fill_q <= 2'd0;
    end
  end

  assign bus.cnt       = cnt_q;
  assign bus.cap0      = cap0_q;
  assign bus.cap1      = cap1_q;
  assign bus.cap2      = cap2_q;
  assign bus.cap_valid = valid_q;
  assign bus.hist_full = (fill_q == 2'd3);
  assign bus.timeout   = at_max;

endmodule
